// File: rtl/axi_pkg.sv
// Shared AXI address-channel definitions: default field widths, request layout
// and the destination code used for the default (DECERR) slave.
package axi_pkg;

    localparam int AXI_IDS_BITS   = 8;
    localparam int AXI_ADDR_BITS  = 32;
    localparam int AXI_LEN_BITS   = 4;
    localparam int AXI_SIZE_BITS  = 3;
    localparam int AXI_BURST_BITS = 2;

    typedef struct packed {
        logic [AXI_IDS_BITS-1:0]   id;
        logic [AXI_ADDR_BITS-1:0]  addr;
        logic [AXI_LEN_BITS-1:0]   len;
        logic [AXI_SIZE_BITS-1:0]  size;
        logic [AXI_BURST_BITS-1:0] burst;
    } axi_req_t;

    // The default slave is encoded one past the last mapped slave.
    function automatic int unsigned axi_def_dest(input int unsigned num_s);
        return num_s;
    endfunction

endpackage

// File: rtl/axi_skid_fifo2.sv
// Two-entry skid buffer for any AXI channel payload. Ready depends only on the
// registered fill level, so it never combinationally follows the pop side.
module axi_skid_fifo2
    import axi_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_srst,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    input  logic         i_pop
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;

    assign o_ready = !i_srst && (r_cnt != 2'd2);
    assign o_empty = (r_cnt == 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_valid && o_ready;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= !r_wr_ptr;
            if (w_pop)  r_rd_ptr <= !r_rd_ptr;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 2'd1;
            else if (w_pop && !w_push) r_cnt <= r_cnt - 2'd1;
        end
    end

endmodule

// File: rtl/axi_addr_router.sv
// AXI AR/AW router: skid buffer, base/mask decode, registered output stage and
// an outstanding counter that holds off a target switch until responses drain.
module axi_addr_router
    import axi_pkg::*;
#(
    parameter int NUM_S     = 6,
    parameter int ID_W      = AXI_IDS_BITS,
    parameter int ADDR_W    = AXI_ADDR_BITS,
    parameter int LEN_W     = AXI_LEN_BITS,
    parameter int SIZE_W    = AXI_SIZE_BITS,
    parameter int MAX_OUTST = 4,
    parameter logic [NUM_S*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_S*ADDR_W-1:0] SLV_MASK = '1
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [ID_W-1:0]                   AID_M,
    input  logic [ADDR_W-1:0]                 ADDR_M,
    input  logic [LEN_W-1:0]                  ALEN_M,
    input  logic [SIZE_W-1:0]                 ASIZE_M,
    input  logic [1:0]                        ABURST_M,
    input  logic                              AVALID_M,
    output logic                              AREADY_M,
    output logic [NUM_S*ID_W-1:0]             AID_S,
    output logic [NUM_S*ADDR_W-1:0]           ADDR_S,
    output logic [NUM_S*LEN_W-1:0]            ALEN_S,
    output logic [NUM_S*SIZE_W-1:0]           ASIZE_S,
    output logic [NUM_S*2-1:0]                ABURST_S,
    output logic [NUM_S-1:0]                  AVALID_S,
    input  logic [NUM_S-1:0]                  AREADY_S,
    output logic [ID_W-1:0]                   AID_DEF,
    output logic                              AVALID_DEF,
    input  logic                              AREADY_DEF,
    input  logic                              RESP_DONE,
    output logic [$clog2(NUM_S+1)-1:0]        CUR_SLAVE,
    output logic [$clog2(MAX_OUTST+1)-1:0]    OUTST_CNT
);

    localparam int CS_W  = $clog2(NUM_S+1);
    localparam int CNT_W = $clog2(MAX_OUTST+1);
    localparam logic [CS_W-1:0]  DEF_DEST = CS_W'(axi_def_dest(NUM_S));
    localparam logic [CNT_W:0]   MAX_EFF  = (CNT_W+1)'(MAX_OUTST);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
        logic [1:0]        burst;
    } req_t;

    req_t             w_req_in;
    req_t             w_head;
    logic             w_empty;
    logic             w_issue;
    logic             w_hs;
    logic             w_dec;
    logic             w_def_sel;
    logic [NUM_S-1:0] w_sel;
    logic [CS_W-1:0]  w_dest;
    logic [CNT_W:0]   w_eff;

    req_t             r_out;
    logic             r_out_valid;
    logic [CS_W-1:0]  r_out_dest;
    logic [CS_W-1:0]  r_cur;
    logic [CNT_W-1:0] r_cnt;

    assign w_req_in = '{id: AID_M, addr: ADDR_M, len: ALEN_M, size: ASIZE_M, burst: ABURST_M};

    axi_skid_fifo2 #(
        .W ($bits(req_t))
    ) u_skid (
        .i_clk   (ACLK),
        .i_srst  (ARESET),
        .i_data  (w_req_in),
        .i_valid (AVALID_M),
        .o_ready (AREADY_M),
        .o_data  (w_head),
        .o_empty (w_empty),
        .i_pop   (w_issue)
    );

    // Scanning downwards lets the lowest matching index overwrite the others.
    always_comb begin
        w_dest = DEF_DEST;
        for (int k = NUM_S - 1; k >= 0; k--) begin
            if ((w_head.addr & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W]) begin
                w_dest = CS_W'(k);
            end
        end
    end

    assign w_def_sel = r_out_valid && (r_out_dest == DEF_DEST);
    assign w_hs      = (|(w_sel & AREADY_S)) || (w_def_sel && AREADY_DEF);
    assign w_dec     = RESP_DONE && (r_cnt != '0);
    assign w_eff     = {1'b0, r_cnt} + {{CNT_W{1'b0}}, r_out_valid};

    // A beat still in the output register counts as outstanding to r_cur, so a
    // switch also waits for it; otherwise the old target's count could land
    // after CUR_SLAVE already names the new one.
    assign w_issue = !w_empty && (!r_out_valid || w_hs)
                  && ((w_eff == '0) || (w_dest == r_cur))
                  && (w_eff < MAX_EFF);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_dest  <= '0;
            r_cur       <= '0;
            r_cnt       <= '0;
        end else begin
            if (w_issue) begin
                r_out       <= w_head;
                r_out_dest  <= w_dest;
                r_out_valid <= 1'b1;
                r_cur       <= w_dest;
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
            end
            if (w_hs && !w_dec)      r_cnt <= r_cnt + CNT_W'(1);
            else if (w_dec && !w_hs) r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_S; gi++) begin : g_slv
            assign w_sel[gi]                       = r_out_valid && (r_out_dest == CS_W'(gi));
            assign AVALID_S[gi]                    = w_sel[gi];
            assign AID_S[gi*ID_W +: ID_W]          = w_sel[gi] ? r_out.id    : '0;
            assign ADDR_S[gi*ADDR_W +: ADDR_W]     = w_sel[gi] ? r_out.addr  : '0;
            assign ALEN_S[gi*LEN_W +: LEN_W]       = w_sel[gi] ? r_out.len   : '0;
            assign ASIZE_S[gi*SIZE_W +: SIZE_W]    = w_sel[gi] ? r_out.size  : '0;
            assign ABURST_S[gi*2 +: 2]             = w_sel[gi] ? r_out.burst : '0;
        end
    endgenerate

    assign AVALID_DEF = w_def_sel;
    assign AID_DEF    = w_def_sel ? r_out.id : '0;
    assign CUR_SLAVE  = r_cur;
    assign OUTST_CNT  = r_cnt;

endmodule
